// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mem_access_unit_pkg : size encodings, FSM states, store lane merge helper |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
package mem_access_unit_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_MERGE = 2'd2
  } state_e;

  // Replace the addressed byte/half lane of a memory word with store data.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] r;
    r = word;
    case (size)
      SIZE_BYTE: r[{off, 3'b000} +: 8]     = wdata[7:0];
      SIZE_HALF: r[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default:   r = wdata;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_extract.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mem_lane_extract : combinational load lane select with sign/zero extend   |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module mem_lane_extract
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{off_i, 3'b000} +: 8];
    half_sel = word_i[{off_i[1], 4'b0000} +: 16];
    case (size_i)
      SIZE_BYTE: data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SIZE_HALF: data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default:   data_o = word_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mem_access_unit : byte/half/word load-store unit with RMW sub-word stores |
// | Option MEM_ACCESS_ALIGN_CHECK_EN: flag misaligned requests on o_err.      |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int RAM_WIDTH = 32,
  parameter int NB_DEPTH  = 10
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_we,
  input  logic [1:0]           i_size,
  input  logic                 i_unsigned,
  input  logic [NB_DEPTH+1:0]  i_addr,
  input  logic [RAM_WIDTH-1:0] i_wdata,
  output logic [RAM_WIDTH-1:0] o_rdata,
  output logic                 o_rvalid,
  output logic                 o_err,
  output logic [NB_DEPTH-1:0]  o_ram_addr,
  output logic [RAM_WIDTH-1:0] o_ram_data,
  output logic                 o_ram_wea,
  output logic                 o_ram_ena,
  input  logic [RAM_WIDTH-1:0] i_ram_data
);

  state_e              state_q;
  logic [NB_DEPTH+1:0] addr_q;
  logic [1:0]          size_q;
  logic                unsigned_q;
  logic [31:0]         wdata_q;

  logic                accept;
  logic [1:0]          size_eff;
  logic                misalign_raw;
  logic                misalign;
  logic [NB_DEPTH+1:0] addr_eff;
  logic [31:0]         lane_data;

  assign o_ready  = (state_q == ST_IDLE) & ~i_rst;
  assign o_rvalid = (state_q == ST_LOAD) & ~i_rst;
  assign accept   = i_valid & o_ready;

  assign size_eff     = (i_size == 2'b11) ? SIZE_WORD : i_size;
  assign misalign_raw = ((size_eff == SIZE_HALF) & i_addr[0]) |
                        ((size_eff == SIZE_WORD) & (i_addr[1:0] != 2'b00));

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  logic err_q;

  assign misalign = misalign_raw;
  assign addr_eff = i_addr;

  // Misaligned requests are consumed without touching the RAM; flag them next cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) err_q <= 1'b0;
    else       err_q <= accept & misalign;
  end

  assign o_err = err_q & ~i_rst;
`else
  assign misalign = 1'b0;
  always_comb begin
    addr_eff = i_addr;
    if (misalign_raw) begin
      if (size_eff == SIZE_HALF) addr_eff[0]   = 1'b0;
      else                       addr_eff[1:0] = 2'b00;
    end
  end

  assign o_err = 1'b0;
`endif

  mem_lane_extract u_lane_extract (
    .word_i     (i_ram_data),
    .size_i     (size_q),
    .off_i      (addr_q[1:0]),
    .unsigned_i (unsigned_q),
    .data_o     (lane_data)
  );

  assign o_rdata = o_rvalid ? lane_data : '0;

  always_comb begin
    o_ram_ena  = 1'b0;
    o_ram_wea  = 1'b0;
    o_ram_addr = addr_eff[NB_DEPTH+1:2];
    o_ram_data = i_wdata;
    if (!i_rst) begin
      case (state_q)
        ST_IDLE: begin
          if (accept && !misalign) begin
            o_ram_ena = 1'b1;
            o_ram_wea = i_we & (size_eff == SIZE_WORD);
          end
        end
        ST_MERGE: begin
          o_ram_ena  = 1'b1;
          o_ram_wea  = 1'b1;
          o_ram_addr = addr_q[NB_DEPTH+1:2];
          o_ram_data = merge_lane(i_ram_data, wdata_q, size_q, addr_q[1:0]);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      size_q     <= SIZE_WORD;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            addr_q     <= addr_eff;
            size_q     <= size_eff;
            unsigned_q <= i_unsigned;
            wdata_q    <= i_wdata;
            if (!misalign) begin
              if (!i_we)                      state_q <= ST_LOAD;
              else if (size_eff != SIZE_WORD) state_q <= ST_MERGE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_mem_access_unit : directed self-checking bench with a write-first RAM  |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_mem_access_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic        i_we;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic [11:0] i_addr;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_rvalid;
  logic        o_err;
  logic [9:0]  o_ram_addr;
  logic [31:0] o_ram_data;
  logic        o_ram_wea;
  logic        o_ram_ena;
  logic [31:0] i_ram_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:1023];

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (o_ram_ena) begin
      if (o_ram_wea) begin
        mem[o_ram_addr] <= o_ram_data;
        i_ram_data      <= o_ram_data;
      end else begin
        i_ram_data <= mem[o_ram_addr];
      end
    end
  end

  mem_access_unit #(.RAM_WIDTH(32), .NB_DEPTH(10)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_we       (i_we),
    .i_size     (i_size),
    .i_unsigned (i_unsigned),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .o_rdata    (o_rdata),
    .o_rvalid   (o_rvalid),
    .o_err      (o_err),
    .o_ram_addr (o_ram_addr),
    .o_ram_data (o_ram_data),
    .o_ram_wea  (o_ram_wea),
    .o_ram_ena  (o_ram_ena),
    .i_ram_data (i_ram_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [11:0] addr, input logic [31:0] wdata);
    i_valid    = 1'b1;
    i_we       = we;
    i_size     = size;
    i_unsigned = uns;
    i_addr     = addr;
    i_wdata    = wdata;
  endtask

  task automatic word_store(input string tag, input logic [11:0] addr, input logic [31:0] d);
    drive(1'b1, 2'b10, 1'b0, addr, d);
    #1;
    chk({tag, "_wea"}, {31'd0, o_ram_wea}, 32'd1);
    chk({tag, "_data"}, o_ram_data, d);
    step();
    i_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                         input logic [11:0] addr, input logic [9:0] exp_waddr,
                         input logic [31:0] exp_data);
    drive(1'b0, size, uns, addr, 32'h0);
    #1;
    chk({tag, "_ena"}, {31'd0, o_ram_ena}, 32'd1);
    chk({tag, "_raddr"}, {22'd0, o_ram_addr}, {22'd0, exp_waddr});
    step();
    i_valid = 1'b0;
    #1;
    chk({tag, "_rvalid"}, {31'd0, o_rvalid}, 32'd1);
    chk({tag, "_rdata"}, o_rdata, exp_data);
    step();
  endtask

  initial begin
    i_rst = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
    i_valid = 1'b0;
    step();
    step();
    chk("rst_rvalid", {31'd0, o_rvalid}, 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
    chk("rst_ena", {31'd0, o_ram_ena}, 32'd0);
    chk("rst_wea", {31'd0, o_ram_wea}, 32'd0);
    chk("rst_err", {31'd0, o_err}, 32'd0);
    i_rst = 1'b0;
    #1;
    chk("rel_ready", {31'd0, o_ready}, 32'd1);

    // Word store then word load
    word_store("sw10", 12'h010, 32'hDEADBEEF);
    do_load("lw10", 2'b10, 1'b0, 12'h010, 10'h004, 32'hDEADBEEF);
    chk("lw10_idle_rdata", o_rdata, 32'd0);
    chk("lw10_idle_ready", {31'd0, o_ready}, 32'd1);

    // Byte store read-modify-write
    word_store("sw10b", 12'h010, 32'h11223344);
    drive(1'b1, 2'b00, 1'b0, 12'h011, 32'h123456AA);
    #1;
    chk("sb_acc_ena", {31'd0, o_ram_ena}, 32'd1);
    chk("sb_acc_wea", {31'd0, o_ram_wea}, 32'd0);
    step();
    i_valid = 1'b0;
    #1;
    chk("sb_mrg_ready", {31'd0, o_ready}, 32'd0);
    chk("sb_mrg_wea", {31'd0, o_ram_wea}, 32'd1);
    chk("sb_mrg_addr", {22'd0, o_ram_addr}, 32'h4);
    chk("sb_mrg_data", o_ram_data, 32'h1122AA44);
    step();
    chk("sb_post_ready", {31'd0, o_ready}, 32'd1);
    chk("sb_post_ena", {31'd0, o_ram_ena}, 32'd0);
    do_load("sb_lw", 2'b10, 1'b0, 12'h010, 10'h004, 32'h1122AA44);

    // Sub-word load extraction and extension
    word_store("sw20", 12'h020, 32'h80FF7F01);
    do_load("lb22", 2'b00, 1'b0, 12'h022, 10'h008, 32'hFFFFFFFF);
    do_load("lbu23", 2'b00, 1'b1, 12'h023, 10'h008, 32'h00000080);
    do_load("lh20", 2'b01, 1'b0, 12'h020, 10'h008, 32'h00007F01);
    do_load("lh22", 2'b01, 1'b0, 12'h022, 10'h008, 32'hFFFF80FF);
    do_load("lhu22", 2'b01, 1'b1, 12'h022, 10'h008, 32'h000080FF);
    do_load("lw_rsv", 2'b11, 1'b0, 12'h020, 10'h008, 32'h80FF7F01);

    // Misaligned word load
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    drive(1'b0, 2'b10, 1'b0, 12'h021, 32'h0);
    #1;
    chk("mis_ena", {31'd0, o_ram_ena}, 32'd0);
    chk("mis_ready", {31'd0, o_ready}, 32'd1);
    step();
    i_valid = 1'b0;
    #1;
    chk("mis_err", {31'd0, o_err}, 32'd1);
    chk("mis_ready2", {31'd0, o_ready}, 32'd1);
    chk("mis_rvalid", {31'd0, o_rvalid}, 32'd0);
    step();
    chk("mis_err_clr", {31'd0, o_err}, 32'd0);
`else
    do_load("mis_lw", 2'b10, 1'b0, 12'h021, 10'h008, 32'h80FF7F01);
    chk("mis_err", {31'd0, o_err}, 32'd0);
`endif

    // Reset during the merge cycle of a half store
    drive(1'b1, 2'b01, 1'b0, 12'h012, 32'h0000BEEF);
    #1;
    chk("sh_acc_ena", {31'd0, o_ram_ena}, 32'd1);
    step();
    i_valid = 1'b0;
    i_rst   = 1'b1;
    #1;
    chk("sh_rst_wea", {31'd0, o_ram_wea}, 32'd0);
    chk("sh_rst_ena", {31'd0, o_ram_ena}, 32'd0);
    step();
    i_rst = 1'b0;
    #1;
    chk("sh_rel_ready", {31'd0, o_ready}, 32'd1);
    do_load("sh_lw", 2'b10, 1'b0, 12'h010, 10'h004, 32'h1122AA44);

    // Back-to-back traffic with i_valid held high
    drive(1'b1, 2'b10, 1'b0, 12'h030, 32'h01010101);
    #1;
    chk("b2b_sw1_wea", {31'd0, o_ram_wea}, 32'd1);
    chk("b2b_sw1_addr", {22'd0, o_ram_addr}, 32'hC);
    step();
    drive(1'b1, 2'b10, 1'b0, 12'h034, 32'h02020202);
    #1;
    chk("b2b_sw2_wea", {31'd0, o_ram_wea}, 32'd1);
    chk("b2b_sw2_addr", {22'd0, o_ram_addr}, 32'hD);
    step();
    drive(1'b0, 2'b10, 1'b0, 12'h030, 32'h0);
    #1;
    chk("b2b_lw_ready", {31'd0, o_ready}, 32'd1);
    chk("b2b_lw_wea", {31'd0, o_ram_wea}, 32'd0);
    step();
    chk("b2b_ld_ready", {31'd0, o_ready}, 32'd0);
    chk("b2b_ld_ena", {31'd0, o_ram_ena}, 32'd0);
    chk("b2b_ld_rdata", o_rdata, 32'h01010101);
    i_valid = 1'b0;
    step();
    chk("b2b_post_ready", {31'd0, o_ready}, 32'd1);
    do_load("b2b_lw2", 2'b10, 1'b0, 12'h034, 10'h00D, 32'h02020202);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter RAM_WIDTH, default 32, meaning the data memory word width in bits; it is fixed at 32.
REQ-002 The block SHALL have parameter NB_DEPTH, default 10, meaning the width of the word address; the memory holds 2**NB_DEPTH words.
REQ-003 The block SHALL have i_clk, input, 1 bit, the clock; all logic samples on its rising edge.
REQ-004 The block SHALL have i_rst, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have i_valid, input, 1 bit, meaning a request is present.
REQ-006 The block SHALL have o_ready, output, 1 bit, meaning the block can accept a request this cycle.
REQ-007 The block SHALL have i_we, input, 1 bit: 1 means store, 0 means load.
REQ-008 The block SHALL have i_size, input, 2 bits: 00 is byte, 01 is half, 10 is word, and 11 is reserved and treated as word.
REQ-009 The block SHALL have i_unsigned, input, 1 bit: 1 means zero-extend a sub-word load, 0 means sign-extend it.
REQ-010 The block SHALL have i_addr, input, NB_DEPTH+2 bits, the byte address.
REQ-011 The block SHALL have i_wdata, input, 32 bits, the store data, right-aligned.
REQ-012 The block SHALL have o_rdata, output, 32 bits, the extracted and extended load result.
REQ-013 The block SHALL have o_rvalid, output, 1 bit, meaning o_rdata is valid this cycle.
REQ-014 The block SHALL have o_err, output, 1 bit, a one-cycle misalignment pulse.
REQ-015 The block SHALL have the RAM port outputs o_ram_addr (NB_DEPTH bits, word address), o_ram_data (32 bits), o_ram_wea (1 bit) and o_ram_ena (1 bit).
REQ-016 The block SHALL have i_ram_data, input, 32 bits, the RAM read data, which has 1-cycle latency (write-first RAM, no output register).

Function
REQ-017 The state machine SHALL have three states: IDLE, LOAD and MERGE.
REQ-018 o_ready SHALL be 1 only in IDLE, and a request SHALL be accepted when i_valid and o_ready are both 1.
REQ-019 A word store SHALL drive the RAM in the accept cycle with ena=1, wea=1, data=i_wdata; the FSM stays in IDLE (1 cycle, full throughput).
REQ-020 A load SHALL drive the RAM in the accept cycle with ena=1 and wea=0, then move to LOAD.
REQ-021 In LOAD, o_rvalid SHALL be 1 and o_rdata SHALL be the extracted lane of i_ram_data; the next state is IDLE.
REQ-022 A byte or half store SHALL issue a read of the word in the accept cycle, then move to MERGE.
REQ-023 In MERGE, the block SHALL drive ena=1, wea=1, and data equal to i_ram_data with the target lane replaced by the latched wdata; the next state is IDLE.
REQ-024 Byte lanes SHALL be little-endian: byte k is bits [8k+7:8k] with k=addr[1:0]; the half lane is selected by addr[1].
REQ-025 Extension SHALL follow i_unsigned for byte and half loads; a word load SHALL be returned unmodified.
REQ-026 Address, size, unsigned flag and wdata SHALL be latched at accept for use in LOAD and MERGE.
REQ-027 A half access with addr[0]=1, or a word access with addr[1:0]!=0, is misaligned and SHALL be handled as defined in the Configuration section.
REQ-028 Outside an access, o_ram_ena and o_ram_wea SHALL be 0 and o_rdata SHALL be 0.
REQ-029 i_valid SHALL be ignored while o_ready=0, and no request queuing SHALL take place.

Reset
REQ-030 While i_rst=1, the state SHALL be IDLE, o_rvalid=0, o_err=0, o_rdata=0, o_ram_ena=0 and o_ram_wea=0.
REQ-031 Reset asserted in LOAD or MERGE SHALL abandon the operation, with no RAM write issued in that cycle.
REQ-032 o_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-033 With MEM_ACCESS_ALIGN_CHECK_EN defined, a misaligned request SHALL be accepted, SHALL issue no RAM access, SHALL leave the FSM in IDLE, and SHALL assert o_err for the single cycle after acceptance.
REQ-034 With MEM_ACCESS_ALIGN_CHECK_EN undefined, o_err SHALL be tied to 0, the offending low address bits SHALL be ignored (half forced to addr[0]=0, word forced to addr[1:0]=0), and the access SHALL proceed normally.

Structure
REQ-035 A shared package SHALL hold the size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and the state enumeration.
REQ-036 The lane extract and extend logic SHALL be one sub-module, mem_lane_extract, which is combinational and also reused by the writeback stage.

Verification
REQ-037 The bench SHALL cover a word store then a load: SW 0xDEADBEEF at 0x010, then LW 0x010 -> o_rvalid asserted 1 cycle after accept, o_rdata=0xDEADBEEF.
REQ-038 The bench SHALL cover a byte store RMW: memory word 0x11223344, SB 0xAA at addr 0x011 -> read in the accept cycle, write 0x1122AA44 in MERGE, o_ready=0 for exactly 1 cycle.
REQ-039 The bench SHALL cover sign extension: word 0x80FF7F01 at 0x020, LB 0x022 -> 0xFFFFFFFF; LBU 0x023 -> 0x00000080; LH 0x020 -> 0x00007F01.
REQ-040 The bench SHALL cover misalignment: LW 0x021 with the macro defined -> o_err=1 one cycle, o_ram_ena=0, o_ready stays 1; without the macro -> reads word 0x020.
REQ-041 The bench SHALL cover reset mid-RMW: SH accepted, i_rst=1 in the MERGE cycle -> o_ram_wea=0, memory unchanged, IDLE after release.
REQ-042 The bench SHALL cover back-to-back traffic: SW, SW, LW with i_valid held high -> two writes on consecutive cycles, then a load with o_ready low 1 cycle.
